// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator.
//   DEF_RESET_PC / DEF_EX_PC : default reset PC and general exception vector
//   fetch_state_e            : generator FSM states
//   gen_mask()               : valid-lane mask for one fetch group (up to 4 lanes)
package fetch_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EX_PC    = 32'hBFC0_0380;

   typedef enum logic [0:0] {
      RUN       = 1'b0,
      ADEL_HOLD = 1'b1
   } fetch_state_e;

   // Lanes s..fetch_width-1 are valid; when trunc is set, lanes above slot
   // are dropped because control leaves the group at the predicted branch.
   function automatic logic [3:0] gen_mask(input logic [1:0] s,
                                           input logic       trunc,
                                           input logic [1:0] slot,
                                           input int         fetch_width);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if ((i < fetch_width) && (i >= int'(s)) && !(trunc && (i > int'(slot)))) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/fetch_credit_counter.sv
// Outstanding-request credit counter.
//   clk, reset : clock, synchronous active-high reset
//   inc        : one request accepted this cycle
//   dec        : one request completed this cycle (ignored at zero)
//   full       : count has reached Q_DEPTH
//   count      : current number of outstanding requests
module fetch_credit_counter
   import fetch_pkg::*;
#(
   parameter int Q_DEPTH = 4,
   localparam int CNT_W  = $clog2(Q_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;
   logic             dec_eff_s;

   // A completion with nothing outstanding must not underflow the counter.
   always_comb begin
      dec_eff_s = dec & (count_r != {CNT_W{1'b0}});
   end

   // Count register: simultaneous inc and dec cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc && !dec_eff_s) begin
         count_r <= count_r + CNT_W'(1);
      end else if (!inc && dec_eff_s) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign full  = (count_r == CNT_W'(Q_DEPTH));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator driving the ICache request port.
//   Redirect inputs : eret_valid/eret_pc, ex_flush, br_redirect/br_target
//   Prediction      : bpu_valid, bpu_slot, bpu_target (same-cycle, for req_pc)
//   Request port    : req_valid/req_ready, req_pc, req_mask, req_epoch, req_adel
//   Completion      : resp_done releases one outstanding-request credit
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int          FETCH_WIDTH = 2,
   parameter int          Q_DEPTH     = 4,
   parameter int          EPOCH_W     = 2,
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [31:0] EX_PC       = DEF_EX_PC,
   localparam int         SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   eret_valid,
   input  logic [31:0]            eret_pc,
   input  logic                   ex_flush,
   input  logic                   br_redirect,
   input  logic [31:0]            br_target,
   input  logic                   bpu_valid,
   input  logic [SLOT_W-1:0]      bpu_slot,
   input  logic [31:0]            bpu_target,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [31:0]            req_pc,
   output logic [FETCH_WIDTH-1:0] req_mask,
   output logic [EPOCH_W-1:0]     req_epoch,
   output logic                   req_adel,
   input  logic                   resp_done
);

   localparam logic [31:0] GB_MASK = ~(32'(FETCH_WIDTH * 4) - 32'd1);
   localparam logic [31:0] GB_INC  = 32'(FETCH_WIDTH * 4);
   localparam int          CNT_W   = $clog2(Q_DEPTH + 1);

   logic [31:0]        req_pc_r, next_pc_s, seq_pc_s;
   logic [EPOCH_W-1:0] epoch_r;
   fetch_state_e       state_r, next_state_s;
   logic [SLOT_W-1:0]  slot_s;
   logic               misalign_s, bpu_eff_s, redirect_s, fire_s, full_s, valid_s;
   logic [CNT_W-1:0]   credit_cnt_s;

   fetch_credit_counter #(.Q_DEPTH(Q_DEPTH)) u_credits (
      .clk   (clk),
      .reset (reset),
      .inc   (fire_s),
      .dec   (resp_done),
      .full  (full_s),
      .count (credit_cnt_s)
   );

   // Group decode: start lane, alignment, prediction qualification, handshake.
   always_comb begin
      if (FETCH_WIDTH == 1) begin
         slot_s = {SLOT_W{1'b0}};
      end else begin
         slot_s = req_pc_r[SLOT_W+1:2];
      end
      misalign_s = (req_pc_r[1:0] != 2'b00);
      // A prediction for a lane before the start slot belongs to an earlier
      // pass through this group and is ignored.
      bpu_eff_s  = bpu_valid & (bpu_slot >= slot_s) & ~misalign_s;
      redirect_s = eret_valid | ex_flush | br_redirect;
      valid_s    = ~reset & (state_r == RUN) & ~full_s;
      fire_s     = valid_s & req_ready;
      seq_pc_s   = (req_pc_r & GB_MASK) + GB_INC;
   end

   // Request-port outputs derived from the registered PC and state.
   always_comb begin
      req_valid = valid_s;
      req_adel  = ~reset & (state_r == RUN) & misalign_s;
      if (reset) begin
         req_mask = {FETCH_WIDTH{1'b1}};
      end else if ((state_r == RUN) && misalign_s) begin
         req_mask = FETCH_WIDTH'(1);
      end else begin
         req_mask = FETCH_WIDTH'(gen_mask(2'(slot_s), bpu_eff_s, 2'(bpu_slot), FETCH_WIDTH));
      end
   end

   // Next-PC priority select and next-state logic.
   always_comb begin
      next_pc_s    = req_pc_r;
      next_state_s = state_r;
      if (eret_valid) begin
         next_pc_s = eret_pc;
      end else if (ex_flush) begin
         next_pc_s = EX_PC;
      end else if (br_redirect) begin
         next_pc_s = br_target;
      end else if (fire_s && misalign_s) begin
         // The faulting PC is kept so it stays visible until the redirect.
         next_pc_s = req_pc_r;
      end else if (fire_s && bpu_eff_s) begin
         next_pc_s = bpu_target;
      end else if (fire_s) begin
         next_pc_s = seq_pc_s;
      end else begin
         next_pc_s = req_pc_r;
      end

      case (state_r)
         RUN: begin
            if (redirect_s) begin
               next_state_s = RUN;
            end else if (fire_s && misalign_s) begin
               next_state_s = ADEL_HOLD;
            end else begin
               next_state_s = RUN;
            end
         end
         ADEL_HOLD: begin
            if (redirect_s) begin
               next_state_s = RUN;
            end else begin
               next_state_s = ADEL_HOLD;
            end
         end
         default: next_state_s = RUN;
      endcase
   end

   // PC, epoch and FSM state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_pc_r <= RESET_PC;
         epoch_r  <= {EPOCH_W{1'b0}};
         state_r  <= RUN;
      end else begin
         req_pc_r <= next_pc_s;
         state_r  <= next_state_s;
         if (redirect_s) begin
            epoch_r <= epoch_r + EPOCH_W'(1);
         end else begin
            epoch_r <= epoch_r;
         end
      end
   end

   assign req_pc    = req_pc_r;
   assign req_epoch = epoch_r;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen (FETCH_WIDTH=2, Q_DEPTH=4, EPOCH_W=2).
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        eret_valid;
   logic [31:0] eret_pc;
   logic        ex_flush;
   logic        br_redirect;
   logic [31:0] br_target;
   logic        bpu_valid;
   logic [0:0]  bpu_slot;
   logic [31:0] bpu_target;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic [1:0]  req_mask;
   logic [1:0]  req_epoch;
   logic        req_adel;
   logic        resp_done;

   int n_cmp = 0;
   int n_err = 0;
   int fires;

   fetch_pc_gen #(
      .FETCH_WIDTH (2),
      .Q_DEPTH     (4),
      .EPOCH_W     (2),
      .RESET_PC    (32'hBFC0_0000),
      .EX_PC       (32'hBFC0_0380)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .eret_valid  (eret_valid),
      .eret_pc     (eret_pc),
      .ex_flush    (ex_flush),
      .br_redirect (br_redirect),
      .br_target   (br_target),
      .bpu_valid   (bpu_valid),
      .bpu_slot    (bpu_slot),
      .bpu_target  (bpu_target),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_pc      (req_pc),
      .req_mask    (req_mask),
      .req_epoch   (req_epoch),
      .req_adel    (req_adel),
      .resp_done   (resp_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic count_fires(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         settle;
         if (req_valid && req_ready) n++;
         step;
      end
   endtask

   initial begin
      reset = 1'b1; eret_valid = 1'b0; eret_pc = 32'h0; ex_flush = 1'b0;
      br_redirect = 1'b0; br_target = 32'h0; bpu_valid = 1'b0; bpu_slot = 1'b0;
      bpu_target = 32'h0; req_ready = 1'b0; resp_done = 1'b0;
      step; step; settle;
      check_val("rst_valid", 32'(req_valid), 32'd0);
      check_val("rst_adel",  32'(req_adel),  32'd0);
      check_val("rst_mask",  32'(req_mask),  32'h3);

      // Release reset, sequential fetch with one group per cycle.
      reset = 1'b0; settle;
      check_val("first_valid", 32'(req_valid), 32'd1);
      check_val("first_pc",    req_pc,         32'hBFC0_0000);
      check_val("first_epoch", 32'(req_epoch), 32'd0);
      check_val("first_mask",  32'(req_mask),  32'h3);
      req_ready = 1'b1; resp_done = 1'b1;
      step; check_val("seq_pc1", req_pc, 32'hBFC0_0008);
      step; check_val("seq_pc2", req_pc, 32'hBFC0_0010);
      check_val("seq_mask", 32'(req_mask), 32'h3);

      // Redirect to the odd lane, then a taken prediction in lane 1.
      req_ready = 1'b0; resp_done = 1'b0; br_redirect = 1'b1; br_target = 32'hBFC0_0004;
      step; br_redirect = 1'b0;
      check_val("br_pc",    req_pc,         32'hBFC0_0004);
      check_val("br_epoch", 32'(req_epoch), 32'd1);
      req_ready = 1'b1; resp_done = 1'b1;
      bpu_valid = 1'b1; bpu_slot = 1'b1; bpu_target = 32'h8000_1000; settle;
      check_val("bpu1_mask", 32'(req_mask), 32'h2);
      step; check_val("bpu1_pc", req_pc, 32'h8000_1000);

      // Same group, prediction in lane 0 lies before the start lane: ignored.
      req_ready = 1'b0; resp_done = 1'b0; bpu_valid = 1'b0; br_redirect = 1'b1;
      step; br_redirect = 1'b0;
      check_val("br2_epoch", 32'(req_epoch), 32'd2);
      req_ready = 1'b1; resp_done = 1'b1; bpu_valid = 1'b1; bpu_slot = 1'b0; settle;
      check_val("bpu0_mask", 32'(req_mask), 32'h2);
      step; check_val("bpu0_pc", req_pc, 32'hBFC0_0008);

      // Aligned group, prediction in lane 0 truncates lane 1.
      bpu_target = 32'h8000_2000; settle;
      check_val("trunc_mask", 32'(req_mask), 32'h1);
      step; check_val("trunc_pc", req_pc, 32'h8000_2000);
      bpu_valid = 1'b0;

      // All three redirects while stalled: ERET wins.
      req_ready = 1'b0; resp_done = 1'b0;
      eret_valid = 1'b1; eret_pc = 32'h8000_3000; ex_flush = 1'b1;
      br_redirect = 1'b1; br_target = 32'h8000_4000;
      step; eret_valid = 1'b0; ex_flush = 1'b0; br_redirect = 1'b0;
      check_val("eret_pc",    req_pc,         32'h8000_3000);
      check_val("eret_epoch", 32'(req_epoch), 32'd3);

      // One credit is outstanding; drain it, then saturate the queue.
      resp_done = 1'b1; step; resp_done = 1'b0;
      req_ready = 1'b1;
      count_fires(8, fires);
      check_val("credit_fires", 32'(fires), 32'd4);
      settle; check_val("credit_full_valid", 32'(req_valid), 32'd0);
      resp_done = 1'b1; step; resp_done = 1'b0; settle;
      check_val("credit_reenable", 32'(req_valid), 32'd1);
      count_fires(5, fires);
      check_val("credit_one_more", 32'(fires), 32'd1);

      // Drain all four, then redirect to a misaligned PC.
      req_ready = 1'b0; resp_done = 1'b1;
      for (int i = 0; i < 4; i++) step;
      resp_done = 1'b0;
      br_redirect = 1'b1; br_target = 32'h8000_0002;
      step; br_redirect = 1'b0;
      check_val("adel_pc",    req_pc,         32'h8000_0002);
      check_val("adel_flag",  32'(req_adel),  32'd1);
      check_val("adel_mask",  32'(req_mask),  32'h1);
      check_val("adel_valid", 32'(req_valid), 32'd1);
      check_val("adel_epoch", 32'(req_epoch), 32'd0);
      req_ready = 1'b1;
      step; check_val("hold_valid", 32'(req_valid), 32'd0);
      check_val("hold_pc", req_pc, 32'h8000_0002);
      step; check_val("hold_valid2", 32'(req_valid), 32'd0);
      ex_flush = 1'b1; step; ex_flush = 1'b0; settle;
      check_val("exc_pc",    req_pc,         32'hBFC0_0380);
      check_val("exc_valid", 32'(req_valid), 32'd1);
      check_val("exc_adel",  32'(req_adel),  32'd0);
      check_val("exc_epoch", 32'(req_epoch), 32'd1);

      // Mid-stream reset with one credit still outstanding.
      req_ready = 1'b0; reset = 1'b1;
      step; check_val("mid_rst_valid", 32'(req_valid), 32'd0);
      reset = 1'b0; settle;
      check_val("mid_rst_pc",    req_pc,         32'hBFC0_0000);
      check_val("mid_rst_epoch", 32'(req_epoch), 32'd0);
      check_val("mid_rst_valid2", 32'(req_valid), 32'd1);

      // Epoch wraps 1,2,3,0; last target exercises the 32-bit wrap.
      br_redirect = 1'b1;
      br_target = 32'h8000_0010; step; check_val("wrap_e1", 32'(req_epoch), 32'd1);
      br_target = 32'h8000_0020; step; check_val("wrap_e2", 32'(req_epoch), 32'd2);
      br_target = 32'h8000_0030; step; check_val("wrap_e3", 32'(req_epoch), 32'd3);
      br_target = 32'hFFFF_FFF8; step; check_val("wrap_e0", 32'(req_epoch), 32'd0);
      br_redirect = 1'b0;
      check_val("wrap_pc_pre", req_pc, 32'hFFFF_FFF8);
      req_ready = 1'b1;
      step; check_val("wrap_pc", req_pc, 32'h0000_0000);

      // One credit in use since reset; three more fit.
      count_fires(6, fires);
      check_val("post_rst_credits", 32'(fires), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
